// File: rtl/nf_merge_avlstrm_pkg.sv
// Shared types and constants for the non-fast-pattern stream merge.
package nf_merge_avlstrm_pkg;

   localparam int PKT_DWIDTH = 512;
   localparam int PKT_EWIDTH = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } merge_state_t;

endpackage

// File: rtl/avl_stream_if.sv
// Avalon-ST packet stream bundle, ready latency 0.
interface avl_stream_if #(
   parameter int DWIDTH = 512,
   parameter int EWIDTH = 6
);
   logic [DWIDTH-1:0] data;
   logic              valid;
   logic              ready;
   logic              sop;
   logic              eop;
   logic [EWIDTH-1:0] empty;

   modport rx (input data, valid, sop, eop, empty, output ready);
   modport tx (output data, valid, sop, eop, empty, input ready);
endinterface

// File: rtl/nf_merge_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves only when a packet is released.
module nf_merge_rr_arb (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [1:0] req_i,
   input  logic       lock_i,
   input  logic [1:0] rel_i,
   output logic [1:0] grant_o
);

   logic last_q, last_d;

   always_comb begin
      last_d  = last_q;
      grant_o = 2'b00;
      if (rel_i[0]) begin
         last_d = 1'b0;
      end else if (rel_i[1]) begin
         last_d = 1'b1;
      end
      // A tie goes to whichever input did not finish the previous packet.
      if (!lock_i) begin
         case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/nf_merge_avlstrm.sv
// Packet-atomic 2:1 Avalon-ST merge with a registered output beat.
// Optional packet counters are built only when NF_MERGE_STATS_EN is defined.
module nf_merge_avlstrm
   import nf_merge_avlstrm_pkg::*;
#(
   parameter int DWIDTH = PKT_DWIDTH,
   parameter int EWIDTH = PKT_EWIDTH
) (
   input  logic        Clk,
   input  logic        Rst,
   avl_stream_if.rx    in0,
   avl_stream_if.rx    in1,
   avl_stream_if.tx    out,
   output logic [31:0] stats_in0_pkt,
   output logic [31:0] stats_in1_pkt,
   output logic [31:0] stats_out_pkt_s
);

   merge_state_t      state_q, state_d;
   logic [1:0]        grant;
   logic [1:0]        rel;
   logic              slot_free;
   logic              in0_rdy, in1_rdy;
   logic              acc0, acc1;
   logic              out_valid_q, out_valid_d;
   logic              out_sop_q, out_sop_d;
   logic              out_eop_q, out_eop_d;
   logic [DWIDTH-1:0] out_data_q, out_data_d;
   logic [EWIDTH-1:0] out_empty_q, out_empty_d;

   nf_merge_rr_arb u_arb (
      .Clk     (Clk),
      .Rst     (Rst),
      .req_i   ({in1.valid, in0.valid}),
      .lock_i  (state_q != IDLE),
      .rel_i   (rel),
      .grant_o (grant)
   );

   assign slot_free = !out_valid_q || out.ready;

   always_comb begin
      in0_rdy = 1'b0;
      in1_rdy = 1'b0;
      case (state_q)
         IDLE: begin
            in0_rdy = grant[0] && slot_free;
            in1_rdy = grant[1] && slot_free;
         end
         LOCK0:   in0_rdy = slot_free;
         LOCK1:   in1_rdy = slot_free;
         default: ;
      endcase
      if (Rst) begin
         in0_rdy = 1'b0;
         in1_rdy = 1'b0;
      end
   end

   assign in0.ready = in0_rdy;
   assign in1.ready = in1_rdy;
   assign acc0      = in0.valid && in0_rdy;
   assign acc1      = in1.valid && in1_rdy;
   assign rel       = {acc1 && in1.eop, acc0 && in0.eop};

   // Single-beat packets never leave IDLE; multi-beat packets lock until eop.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (acc0 && !in0.eop) begin
               state_d = LOCK0;
            end else if (acc1 && !in1.eop) begin
               state_d = LOCK1;
            end
         end
         LOCK0:   if (rel[0]) state_d = IDLE;
         LOCK1:   if (rel[1]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_sop_d   = out_sop_q;
      out_eop_d   = out_eop_q;
      out_empty_d = out_empty_q;
      out_valid_d = out_valid_q;
      if (acc1) begin
         out_data_d  = in1.data;
         out_sop_d   = in1.sop;
         out_eop_d   = in1.eop;
         out_empty_d = in1.empty;
      end else if (acc0) begin
         out_data_d  = in0.data;
         out_sop_d   = in0.sop;
         out_eop_d   = in0.eop;
         out_empty_d = in0.empty;
      end
      // A fresh accept wins over a drain so back-to-back beats have no bubble.
      if (acc0 || acc1) begin
         out_valid_d = 1'b1;
      end else if (out.ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_empty_q <= '0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
         out_empty_q <= out_empty_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out.valid = out_valid_q;
   assign out.sop   = out_sop_q;
   assign out.eop   = out_eop_q;
   assign out.empty = out_empty_q;
   assign out.data  = out_data_q;

`ifdef NF_MERGE_STATS_EN
   logic [31:0] cnt_in0_q, cnt_in0_d;
   logic [31:0] cnt_in1_q, cnt_in1_d;
   logic [31:0] cnt_out_q, cnt_out_d;

   always_comb begin
      cnt_in0_d = cnt_in0_q + {31'd0, rel[0]};
      cnt_in1_d = cnt_in1_q + {31'd0, rel[1]};
      cnt_out_d = cnt_out_q + {31'd0, out_valid_q && out.ready && out_sop_q};
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt_in0_q <= 32'd0;
         cnt_in1_q <= 32'd0;
         cnt_out_q <= 32'd0;
      end else begin
         cnt_in0_q <= cnt_in0_d;
         cnt_in1_q <= cnt_in1_d;
         cnt_out_q <= cnt_out_d;
      end
   end

   assign stats_in0_pkt   = cnt_in0_q;
   assign stats_in1_pkt   = cnt_in1_q;
   assign stats_out_pkt_s = cnt_out_q;
`else
   assign stats_in0_pkt   = 32'd0;
   assign stats_in1_pkt   = 32'd0;
   assign stats_out_pkt_s = 32'd0;
`endif

endmodule

// File: doc/nf_merge_avlstrm.md
# nf_merge_avlstrm

- Packet-atomic 2:1 merge of two 512-bit Avalon-ST packet streams into one.
- Counterpart of the non-fast-pattern fork: recombines the no-check path and the checked path into a single stream ahead of the packet-out channel.
- Arbitrates only at packet boundaries (round-robin) and registers the output beat.
- Keeps per-input packet counters for the stats block.

## Interface

- DWIDTH, 512: data bus width in bits.
- EWIDTH, 6: width of `empty`, equal to log2(DWIDTH/8).
- Clk, input, 1: the single clock.
- Rst, input, 1: reset, synchronous, active-high.
- in0, avl_stream_if.rx, DWIDTH: no-check stream. Fields: data, valid, ready, sop, eop, empty.
- in1, avl_stream_if.rx, DWIDTH: checked stream. Same fields as in0.
- out, avl_stream_if.tx, DWIDTH: merged stream.
- stats_in0_pkt, output, 32: count of in0 packets forwarded (eop beats).
- stats_in1_pkt, output, 32: count of in1 packets forwarded.
- stats_out_pkt_s, output, 32: count of out sop beats accepted.

## Operation

- A beat transfers on an interface when valid && ready in the same cycle (ready latency 0).
- FSM states:
  - IDLE: no packet is locked.
  - LOCK0: in0 owns the output until its eop.
  - LOCK1: in1 owns the output until its eop.
- Grant in IDLE, evaluated each cycle:
  - only in0.valid → LOCK0; only in1.valid → LOCK1.
  - both valid → the input not granted last (last_grant pointer).
  - last_grant resets to 1, so in0 wins the first tie.
- The granting cycle also accepts the first beat. The combinational grant drives the ready of the same cycle.
- In LOCKx, inx.ready = !out.valid || out.ready. The other input's ready = 0.
- An accepted beat with eop=1:
  - the state returns to IDLE on the next cycle;
  - last_grant := x.
- A single-beat packet (sop && eop) is accepted in IDLE and leaves the state in IDLE.
- sop is not used for arbitration. A protocol-violating sop mid-packet is forwarded unchanged.
- Output register: data, sop, eop, empty are captured from the granted input when its beat is accepted.
- out.valid update:
  - set when a beat is accepted;
  - cleared when out.ready && out.valid and no new beat is accepted that cycle.
- No bubble on back-to-back acceptance: throughput is one beat per cycle while out.ready stays high.
- Back-to-back packets from different inputs: at least one IDLE cycle is allowed between an eop beat and the next grant.
- Counters: 32-bit, increment by 1 on the qualifying accepted beat, wrap from 0xFFFFFFFF to 0.
- Counter timing:
  - stats_inx_pkt counts eop beats at input acceptance;
  - stats_out_pkt_s counts sop beats at output acceptance.

## Timing

- Latency: an input beat accepted in cycle N appears on out in cycle N+1.
- Reset values (registers, on Rst=1 at a clock edge):
  - state=IDLE, last_grant=1;
  - out.valid=0, out.sop=0, out.eop=0, out.empty=0, out.data=0;
  - all counters 0.
- Combinational ready values while Rst=1: in0.ready=in1.ready=0.
- Reset mid-packet: the partial packet is abandoned and the FSM returns to IDLE. The downstream sees no eop for that packet, which is the system reset contract.
- Backpressure: with out.valid=1 && out.ready=0, the output holds all fields stable and both input readies are 0.
- Simultaneous events:
  - out drain and input accept in the same cycle: the register is replaced and out.valid stays 1.
  - eop accept in LOCKx with the other input valid: the other input is granted no earlier than the next cycle.

## Configuration

- NF_MERGE_STATS_EN defined: the three counters are implemented as above.
- NF_MERGE_STATS_EN undefined:
  - counters are not instantiated;
  - all stats outputs are tied to 32'd0;
  - the datapath is identical.

## Structure

- Shared package (struct_s):
  - merge_state_t enum {IDLE, LOCK0, LOCK1};
  - constants PKT_DWIDTH=512 and PKT_EWIDTH=6.
- Natural sub-module: nf_merge_rr_arb.
  - Inputs: req[1:0], lock, release.
  - Output: one-hot grant[1:0].
  - Holds the last_grant pointer.
- The FSM, output register and counters stay in the top module.

## Test plan

- Single-beat packets:
  - Stimulus: in0 only, 4 packets (sop=eop=1, empty=5), out.ready=1.
  - Required: out shows 4 beats, each 1 cycle after input; stats_in0_pkt=4; stats_in1_pkt=0.
- Atomic packets under tie:
  - Stimulus: in0 and in1 both offer 3-beat packets simultaneously, continuously.
  - Required: out carries in0 packet, then in1, alternating; never interleaved within a packet.
- Backpressure:
  - Stimulus: out.ready low for 5 cycles in the middle of an in1 packet.
  - Required: out fields stable; in1.ready=0 for those 5 cycles; no beat lost or duplicated.
- Reset mid-packet:
  - Stimulus: assert Rst after beat 2 of a 4-beat in0 packet.
  - Required: next cycle out.valid=0, state IDLE; after release, in1 is granted at once when it alone is valid.
- Counter wrap:
  - Stimulus: preload stats_in1_pkt to 0xFFFFFFFF via force, then send 1 in1 packet.
  - Required: stats_in1_pkt=0.
- Stats compiled out:
  - Stimulus: build without NF_MERGE_STATS_EN, send 10 packets.
  - Required: all stats outputs stay 0; out stream identical to the stats-enabled run.
